ofm_relu_pool: RTL and testbench
================================

Name: ofm_relu_pool

Overview:
- Downstream post-processing stage for the convolution accelerator.
- Runs after the conv engine has pulsed done on the final input-channel tile. It reads the Tm output-feature-map buffers through their read port and applies 2x2 stride-2 max pooling, then ReLU, to every bank in parallel.
- Writes the pooled results into the next layer's input buffers.
- Uses the same enable/done handshake as the conv engine, so the top-level sequencer drives both the same way.

Parameters:
- DATA_WIDTH, 16, element width; signed two's complement.
- TM, 8, number of parallel OFM banks (one lane per bank).
- OFM_ADR_W, 10, OFM buffer address width.
- POOL_ADR_W, 8, pooled-output buffer address width.
- WOUT, 8, OFM width in elements.
- HOUT, 8, OFM height in elements.

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  start request, sampled in IDLE only
- relu_en  in  1  1 = apply ReLU, 0 = bypass; sampled at start
- done  out  1  one-cycle completion pulse
- busy  out  1  high from start until the done cycle inclusive
- out_buf_read_n  out  1  active-low read strobe, shared by all banks
- out_buf_address  out  OFM_ADR_W  read address, shared
- out_buf_readdata  in  TM*DATA_WIDTH  bank k is bits [k*DW +: DW]; valid 1 cycle after strobe
- pool_buf_write_n  out  1  active-low write strobe, shared
- pool_buf_address  out  POOL_ADR_W  write address, shared
- pool_buf_writedata  out  TM*DATA_WIDTH  bank k is bits [k*DW +: DW]

Behaviour:
- Reset values (asynchronous, on reset_n low): done=0, busy=0, out_buf_read_n=1, pool_buf_write_n=1, all addresses 0, writedata 0, state IDLE, all counters 0.
- Geometry: HP = HOUT/2, WP = WOUT/2 (floor). For odd WOUT or HOUT the last column or row is never read.
- States: IDLE, READ, DRAIN, DONE.
  - IDLE: on enable=1, latch relu_en, clear counters (ph, pw, q), go to READ.
  - READ: one read per cycle with out_buf_read_n=0. Quad index q=0..3 selects the address:
    - q0: (2ph)*WOUT + 2pw
    - q1: q0 + 1
    - q2: q0 + WOUT
    - q3: q0 + WOUT + 1
  - q wraps 3->0 and advances pw. pw wraps WP-1 -> 0 and advances ph.
  - After q3 of pixel (HP-1, WP-1) is issued, go to DRAIN.
  - DRAIN: 2 cycles with no reads, to flush the pipeline. Then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy drops in the cycle after DONE.
- Datapath, per bank, fully pipelined:
  - Readdata for q0 loads the running max.
  - q1..q3 each perform a signed compare and keep the larger value.
  - Once q3 data has been folded in, a register stage applies ReLU: a negative result becomes 0 when relu_en is latched 1.
  - The write is issued with pool_buf_write_n=0 exactly 2 cycles after the q3 read strobe, at address ph*WP + pw of that pixel.
- Timing and throughput:
  - One pooled pixel per 4 cycles; reads are back-to-back with no bubbles.
  - Total time is 4*HP*WP + 3 cycles, from the first READ cycle to the DONE cycle inclusive.
- No arithmetic widening or saturation; values pass through unchanged apart from max and ReLU.
- enable while busy is ignored. enable held high in the cycle after DONE starts a new run.
- relu_en changes mid-run have no effect.
- Reset mid-operation: immediate return to IDLE with all strobes deasserted. No write is issued after reset; partial buffer contents are undefined.
- Degenerate geometry (HP=0 or WP=0): IDLE -> DONE directly, no reads or writes, done pulses 1 cycle after enable.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles, release with enable=0 -> all strobes stay 1, done=0, busy=0 for 20 cycles.
- Basic pool: WOUT=HOUT=4, bank0 OFM = address value (0..15), relu_en=1 -> 4 writes with bank0 data 5, 7, 13, 15 at pool addresses 0..3. Reads occur at addresses 0,1,4,5,2,3,6,7,... Done pulses 19 cycles after the first READ cycle.
- ReLU and signed compare: bank3 quad values {-5,-2,-9,-7}. With relu_en=1 the output is 0; with relu_en=0 it is -2. Quad {-1,0x7FFF,-32768,3} -> 0x7FFF.
- Odd geometry: WOUT=5, HOUT=5 -> HP=WP=2, exactly 4 writes. No read address ever has column 4 or row 4.
- Reset mid-run: assert reset_n=0 during the 6th READ cycle -> read_n=1 and write_n=1 within the same cycle asynchronously; no done pulse. A subsequent run completes correctly.
- Handshake: pulse enable during READ -> ignored, exactly one done. enable held high continuously -> back-to-back runs, each done exactly once, with busy low for exactly one cycle between runs.

Source files
------------

// File: rtl/ofm_relu_pool.sv
// ofm_relu_pool: 2x2/stride-2 max pooling followed by optional ReLU across TM
// OFM banks in parallel. Reads the OFM buffers quad by quad, one read per
// cycle, and writes one pooled pixel per bank every four cycles.
module ofm_relu_pool #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TM         = 8,
  parameter int unsigned OFM_ADR_W  = 10,
  parameter int unsigned POOL_ADR_W = 8,
  parameter int unsigned WOUT       = 8,
  parameter int unsigned HOUT       = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       relu_en,
  output logic                       done,
  output logic                       busy,
  output logic                       out_buf_read_n,
  output logic [OFM_ADR_W-1:0]       out_buf_address,
  input  logic [TM*DATA_WIDTH-1:0]   out_buf_readdata,
  output logic                       pool_buf_write_n,
  output logic [POOL_ADR_W-1:0]      pool_buf_address,
  output logic [TM*DATA_WIDTH-1:0]   pool_buf_writedata
);

  localparam int unsigned HP    = HOUT / 2;
  localparam int unsigned WP    = WOUT / 2;
  localparam int unsigned PH_W  = (HP > 1) ? $clog2(HP) : 1;
  localparam int unsigned PW_W  = (WP > 1) ? $clog2(WP) : 1;
  localparam bit          DEGEN = (HP == 0) || (WP == 0);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                   r_state;
  logic [PH_W-1:0]          r_ph;
  logic [PW_W-1:0]          r_pw;
  logic [1:0]               r_q;
  logic                     r_relu;
  logic                     r_drain;
  logic                     r_tag_vld;
  logic [1:0]               r_tag_q;
  logic [POOL_ADR_W-1:0]    r_tag_padr;
  logic signed [DATA_WIDTH-1:0] r_max [TM];

  logic [PH_W-1:0]          w_ph_nxt;
  logic [PW_W-1:0]          w_pw_nxt;
  logic [1:0]               w_q_nxt;
  logic                     w_pw_last;
  logic                     w_ph_last;
  logic                     w_last;
  logic [OFM_ADR_W-1:0]     w_nxt_addr;
  logic [POOL_ADR_W-1:0]    w_pool_addr;
  logic signed [DATA_WIDTH-1:0] w_rd   [TM];
  logic signed [DATA_WIDTH-1:0] w_fold [TM];
  logic signed [DATA_WIDTH-1:0] w_out  [TM];

  // Quad/pixel counter advance and the address of the next read
  always_comb begin
    w_q_nxt   = r_q + 2'd1;
    w_pw_nxt  = r_pw;
    w_ph_nxt  = r_ph;
    w_pw_last = (r_pw == PW_W'(WP - 1));
    w_ph_last = (r_ph == PH_W'(HP - 1));
    if (r_q == 2'd3) begin
      if (w_pw_last) begin
        w_pw_nxt = '0;
        w_ph_nxt = r_ph + PH_W'(1);
      end else begin
        w_pw_nxt = r_pw + PW_W'(1);
      end
    end
    w_last      = (r_q == 2'd3) && w_pw_last && w_ph_last;
    w_nxt_addr  = OFM_ADR_W'({w_ph_nxt, 1'b0}) * OFM_ADR_W'(WOUT)
                + OFM_ADR_W'({w_pw_nxt, 1'b0})
                + (w_q_nxt[1] ? OFM_ADR_W'(WOUT) : OFM_ADR_W'(0))
                + OFM_ADR_W'(w_q_nxt[0]);
    w_pool_addr = POOL_ADR_W'(r_ph) * POOL_ADR_W'(WP) + POOL_ADR_W'(r_pw);
  end

  // Per-bank signed max fold of returning read data, then ReLU on the result
  always_comb begin
    for (int k = 0; k < int'(TM); k++) begin
      w_rd[k]   = $signed(out_buf_readdata[k*DATA_WIDTH +: DATA_WIDTH]);
      w_fold[k] = (r_tag_q == 2'd0) ? w_rd[k]
                : ((w_rd[k] > r_max[k]) ? w_rd[k] : r_max[k]);
      w_out[k]  = (r_relu && w_fold[k][DATA_WIDTH-1]) ? '0 : w_fold[k];
    end
  end

  // Control FSM: issues reads, drains the pipeline, pulses done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_ph            <= '0;
      r_pw            <= '0;
      r_q             <= '0;
      r_relu          <= 1'b0;
      r_drain         <= 1'b0;
      done            <= 1'b0;
      busy            <= 1'b0;
      out_buf_read_n  <= 1'b1;
      out_buf_address <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_relu <= relu_en;
            r_ph   <= '0;
            r_pw   <= '0;
            r_q    <= '0;
            busy   <= 1'b1;
            if (DEGEN) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end else begin
              r_state         <= S_READ;
              out_buf_read_n  <= 1'b0;
              out_buf_address <= '0;
            end
          end
        end
        S_READ: begin
          if (w_last) begin
            r_state        <= S_DRAIN;
            out_buf_read_n <= 1'b1;
            r_drain        <= 1'b0;
          end else begin
            r_q             <= w_q_nxt;
            r_pw            <= w_pw_nxt;
            r_ph            <= w_ph_nxt;
            out_buf_address <= w_nxt_addr;
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-tag pipeline, running max, and the pooled write two cycles after q3
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_vld          <= 1'b0;
      r_tag_q            <= '0;
      r_tag_padr         <= '0;
      pool_buf_write_n   <= 1'b1;
      pool_buf_address   <= '0;
      pool_buf_writedata <= '0;
      for (int k = 0; k < int'(TM); k++) r_max[k] <= '0;
    end else begin
      r_tag_vld        <= ~out_buf_read_n;
      r_tag_q          <= r_q;
      r_tag_padr       <= w_pool_addr;
      pool_buf_write_n <= 1'b1;
      if (r_tag_vld) begin
        for (int k = 0; k < int'(TM); k++) r_max[k] <= w_fold[k];
        if (r_tag_q == 2'd3) begin
          pool_buf_write_n <= 1'b0;
          pool_buf_address <= r_tag_padr;
          for (int k = 0; k < int'(TM); k++)
            pool_buf_writedata[k*DATA_WIDTH +: DATA_WIDTH] <= w_out[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_ofm_relu_pool.sv
// Bench for ofm_relu_pool: 4x4, 5x5 and degenerate 1x1 instances with
// behavioural OFM read memories and pooled-write capture.
module tb_ofm_relu_pool;

  localparam int DW = 16;
  localparam int TM = 8;
  localparam int BW = DW * TM;

  logic clk = 1'b0;
  logic reset_n;
  logic relu_en;
  always #5 clk = ~clk;

  logic en4, done4, busy4, rd_n4, wr_n4;
  logic [9:0] rd_adr4;
  logic [7:0] wr_adr4;
  logic [BW-1:0] rdata4, wdata4;

  logic en5, done5, busy5, rd_n5, wr_n5;
  logic [9:0] rd_adr5;
  logic [7:0] wr_adr5;
  logic [BW-1:0] rdata5, wdata5;

  logic end_, doned, busyd, rd_nd, wr_nd;
  logic [9:0] rd_adrd;
  logic [7:0] wr_adrd;
  logic [BW-1:0] rdatad, wdatad;

  ofm_relu_pool #(.WOUT(4), .HOUT(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(en4), .relu_en(relu_en),
    .done(done4), .busy(busy4), .out_buf_read_n(rd_n4), .out_buf_address(rd_adr4),
    .out_buf_readdata(rdata4), .pool_buf_write_n(wr_n4), .pool_buf_address(wr_adr4),
    .pool_buf_writedata(wdata4));

  ofm_relu_pool #(.WOUT(5), .HOUT(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .enable(en5), .relu_en(relu_en),
    .done(done5), .busy(busy5), .out_buf_read_n(rd_n5), .out_buf_address(rd_adr5),
    .out_buf_readdata(rdata5), .pool_buf_write_n(wr_n5), .pool_buf_address(wr_adr5),
    .pool_buf_writedata(wdata5));

  ofm_relu_pool #(.WOUT(1), .HOUT(1)) dutd (
    .clk(clk), .reset_n(reset_n), .enable(end_), .relu_en(relu_en),
    .done(doned), .busy(busyd), .out_buf_read_n(rd_nd), .out_buf_address(rd_adrd),
    .out_buf_readdata(rdatad), .pool_buf_write_n(wr_nd), .pool_buf_address(wr_adrd),
    .pool_buf_writedata(wdatad));

  // OFM memories, one-cycle read latency
  logic [DW-1:0] mem4 [TM][16];
  logic [DW-1:0] mem5 [TM][25];
  assign rdatad = '0;

  always @(posedge clk) begin
    if (!rd_n4 && int'(rd_adr4) < 16)
      for (int k = 0; k < TM; k++) rdata4[k*DW +: DW] <= mem4[k][int'(rd_adr4)];
    if (!rd_n5 && int'(rd_adr5) < 25)
      for (int k = 0; k < TM; k++) rdata5[k*DW +: DW] <= mem5[k][int'(rd_adr5)];
  end

  // Monitors
  int cyc = 0;
  int first_rd4, done_cyc4, wr_cnt4, done_cnt4, low_cnt4;
  int rd_cnt5, bad5, wr_cnt5, done_cnt5;
  int rd_cntd, wr_cntd, done_cntd;
  int rdq4[$];
  logic [BW-1:0] pool4 [4];
  logic [BW-1:0] pool5 [4];

  always @(posedge clk) begin
    int a;
    cyc++;
    if (!rd_n4) begin
      if (first_rd4 < 0) first_rd4 = cyc;
      rdq4.push_back(int'(rd_adr4));
    end
    if (!wr_n4) begin wr_cnt4++; pool4[int'(wr_adr4) % 4] = wdata4; end
    if (done4) begin done_cnt4++; done_cyc4 = cyc; end
    if (!busy4) low_cnt4++;
    if (!rd_n5) begin
      rd_cnt5++;
      a = int'(rd_adr5);
      if ((a % 5) == 4 || (a / 5) >= 4) bad5++;
    end
    if (!wr_n5) begin wr_cnt5++; pool5[int'(wr_adr5) % 4] = wdata5; end
    if (done5) done_cnt5++;
    if (!rd_nd) rd_cntd++;
    if (!wr_nd) wr_cntd++;
    if (doned) done_cntd++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    first_rd4 = -1; done_cyc4 = -1; wr_cnt4 = 0; done_cnt4 = 0; low_cnt4 = 0;
    rd_cnt5 = 0; bad5 = 0; wr_cnt5 = 0; done_cnt5 = 0;
    rd_cntd = 0; wr_cntd = 0; done_cntd = 0;
    rdq4.delete();
    for (int i = 0; i < 4; i++) begin pool4[i] = {TM{16'h5A5A}}; pool5[i] = {TM{16'h5A5A}}; end
  endtask

  task automatic wait_done4(input int target);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt4 >= target) break;
      @(posedge clk); #1;
    end
  endtask

  // One 4x4 run; relu_en is flipped right after start and must not matter
  task automatic run4(input logic relu, input logic poke);
    clear_mon();
    relu_en = relu; en4 = 1'b1;
    @(posedge clk); #1;
    en4 = 1'b0; relu_en = ~relu;
    if (poke) begin
      repeat (3) @(posedge clk); #1;
      en4 = 1'b1;
      @(posedge clk); #1;
      en4 = 1'b0;
    end
    wait_done4(1);
    repeat (25) @(posedge clk); #1;
    chk("done_once", done_cnt4, 1);
  endtask

  typedef struct {
    string name;
    logic signed [DW-1:0] v0, v1, v2, v3;
    logic relu;
    logic signed [DW-1:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic set_vec(input int i, input string n, input int a, input int b,
                         input int c, input int d, input logic r, input int e);
    tbl[i].name = n; tbl[i].v0 = 16'(a); tbl[i].v1 = 16'(b); tbl[i].v2 = 16'(c);
    tbl[i].v3 = 16'(d); tbl[i].relu = r; tbl[i].exp = 16'(e);
  endtask

  initial begin
    int exp4 [4];
    int exp5 [4];
    int seq [16];
    int nmis;
    exp4 = '{5, 7, 13, 15};
    exp5 = '{6, 8, 16, 18};
    seq  = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    set_vec(0, "neg_relu",      -5, -2, -9, -7, 1'b1, 0);
    set_vec(1, "neg_bypass",    -5, -2, -9, -7, 1'b0, -2);
    set_vec(2, "mixed_relu",    -1, 32767, -32768, 3, 1'b1, 32767);
    set_vec(3, "mixed_bypass",  -1, 32767, -32768, 3, 1'b0, 32767);
    set_vec(4, "allmin_bypass", -32768, -32768, -32768, -32768, 1'b0, -32768);
    set_vec(5, "q2_max",        100, -200, 300, 299, 1'b1, 300);
    set_vec(6, "q0_max",        9, 4, 3, -2, 1'b0, 9);
    set_vec(7, "q3_max",        -300, -200, -100, -50, 1'b0, -50);

    for (int k = 0; k < TM; k++) begin
      for (int a = 0; a < 16; a++) mem4[k][a] = (k == 0) ? 16'(a) : 16'(0);
      for (int a = 0; a < 25; a++) mem5[k][a] = (k == 0) ? 16'(a) : 16'(0);
    end
    reset_n = 1'b0; en4 = 0; en5 = 0; end_ = 0; relu_en = 0;
    clear_mon();

    // Reset and idle
    repeat (3) @(posedge clk); #1;
    chk("rst_read_n", rd_n4, 1);
    chk("rst_write_n", wr_n4, 1);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_wdata_zero", (wdata4 == '0), 1);
    chk("rst_raddr", rd_adr4, 0);
    reset_n = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk); #1;
    chk("idle_reads", rdq4.size() + rd_cnt5 + rd_cntd, 0);
    chk("idle_writes", wr_cnt4 + wr_cnt5 + wr_cntd, 0);
    chk("idle_dones", done_cnt4 + done_cnt5 + done_cntd, 0);
    chk("idle_busy_low", low_cnt4, 20);

    // Basic 4x4 pool
    run4(1'b1, 1'b0);
    chk("basic_writes", wr_cnt4, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_px%0d", i), pool4[i][DW-1:0], exp4[i]);
    chk("basic_nreads", rdq4.size(), 16);
    nmis = 0;
    for (int i = 0; i < 16 && i < rdq4.size(); i++) if (rdq4[i] != seq[i]) nmis++;
    chk("basic_rd_order", nmis, 0);
    chk("basic_latency", done_cyc4 - first_rd4 + 1, 19);

    // Table: signed max and ReLU on bank 3, pixel 0
    for (int i = 0; i < 8; i++) begin
      mem4[3][0] = tbl[i].v0; mem4[3][1] = tbl[i].v1;
      mem4[3][4] = tbl[i].v2; mem4[3][5] = tbl[i].v3;
      run4(tbl[i].relu, 1'b0);
      chk(tbl[i].name, $signed(pool4[0][3*DW +: DW]), tbl[i].exp);
    end

    // Odd geometry 5x5
    clear_mon();
    relu_en = 1'b1; en5 = 1'b1;
    @(posedge clk); #1;
    en5 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt5 >= 1) break;
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk); #1;
    chk("odd_done", done_cnt5, 1);
    chk("odd_writes", wr_cnt5, 4);
    chk("odd_reads", rd_cnt5, 16);
    chk("odd_bad_addr", bad5, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("odd_px%0d", i), pool5[i][DW-1:0], exp5[i]);

    // Degenerate geometry
    clear_mon();
    end_ = 1'b1;
    @(posedge clk); #1;
    end_ = 1'b0;
    chk("deg_done_next", doned, 1);
    chk("deg_busy", busyd, 1);
    @(posedge clk); #1;
    chk("deg_done_pulse", doned, 0);
    repeat (5) @(posedge clk); #1;
    chk("deg_done_cnt", done_cntd, 1);
    chk("deg_no_access", rd_cntd + wr_cntd, 0);

    // Reset during the 6th READ cycle
    clear_mon();
    relu_en = 1'b1; en4 = 1'b1;
    @(posedge clk); #1;
    en4 = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("mid_pre_read_n", rd_n4, 0);
    chk("mid_pre_write_n", wr_n4, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_read_n", rd_n4, 1);
    chk("mid_write_n", wr_n4, 1);
    chk("mid_busy", busy4, 0);
    clear_mon();
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (25) @(posedge clk); #1;
    chk("mid_no_done", done_cnt4, 0);
    chk("mid_no_write", wr_cnt4, 0);
    run4(1'b1, 1'b0);
    chk("mid_rerun_writes", wr_cnt4, 4);
    chk("mid_rerun_px3", pool4[3][DW-1:0], 15);

    // enable pulsed during READ is ignored
    run4(1'b1, 1'b1);
    chk("poke_writes", wr_cnt4, 4);
    chk("poke_reads", rdq4.size(), 16);

    // enable held high: back-to-back runs with a single idle cycle between
    clear_mon();
    relu_en = 1'b1; en4 = 1'b1;
    @(posedge clk); #1;
    wait_done4(1);
    low_cnt4 = 0;
    wait_done4(2);
    en4 = 1'b0;
    chk("b2b_busy_gap", low_cnt4, 1);
    repeat (25) @(posedge clk); #1;
    chk("b2b_dones", done_cnt4, 2);
    chk("b2b_writes", wr_cnt4, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
